if_stage: RTL

- Instruction-fetch stage. Producer side of the IF/ID pipeline interface that the decode stage (id_stage) consumes.
- Owns the fetch PC and talks to instruction memory through a request/response handshake with variable latency.
- Buffers one returned instruction while the pipeline is stalled.
- Drives if_id_pc, if_id_instruction and if_id_valid, and honours stall, flush and branch/jump redirect from later stages.

---
 rtl/if_stage_pkg.sv | 24 ++
 rtl/if_stage_if.sv | 13 +
 rtl/if_stage_hold_buffer.sv | 25 ++
 rtl/if_stage.sv | 129 ++++++++++++
 4 files changed

// File: rtl/if_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// The FSM encodings, reset PC and NOP word are used by the RTL and the bench alike.
package if_stage_pkg;

  typedef enum logic [1:0] {
    IF_IDLE    = 2'd0,
    IF_WAIT    = 2'd1,
    IF_HOLD    = 2'd2,
    IF_DISCARD = 2'd3
  } if_state_e;

  localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0013;  // ADDI x0,x0,0

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory port of the fetch stage.
// A request transfers in any cycle with req && ready; each transfer returns exactly
// one rvalid/rdata beat later, in order, and at most one transfer is ever outstanding.
interface if_stage_if;
  logic        req;
  logic [31:0] addr;
  logic        ready;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, addr, input ready, rvalid, rdata);
  modport slave  (input req, addr, output ready, rvalid, rdata);
endinterface

// File: rtl/if_stage_hold_buffer.sv
// One-entry {pc, instr} parking register for a fetch response that lands during a stall.
// Clear wins over load so a redirect can drop a just-parked word.
module if_hold_buffer
  import if_stage_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         clear,
  input  fetch_entry_t din,
  output fetch_entry_t dout,
  output logic         full
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      full <= 1'b0;
      dout <= '0;
    end else if (load) begin
      full <= 1'b1;
      dout <= din;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the fetch PC, talks to imem and fills the IF/ID register.
// The FSM tracks the single in-flight request; fsm_state exposes it for observation.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  if_stage_if.master        imem,
  output logic [31:0]       if_id_pc,
  output logic [31:0]       if_id_instruction,
  output logic              if_id_valid,
  output logic [31:0]       fetch_count,
  output if_state_e         fsm_state
);

  if_state_e    state_q, state_d;
  logic [31:0]  pc_reg, pc_d, pc_plus4;
  logic         req, load, hold_load, hold_clear, hold_full;
  logic [31:0]  addr;
  fetch_entry_t load_entry, hold_entry, capture_entry;

  assign pc_plus4      = pc_reg + 32'd4;
  assign capture_entry = '{pc: pc_reg, instr: imem.rdata};

  if_hold_buffer u_hold (
    .clk   (clk),
    .reset (reset),
    .load  (hold_load),
    .clear (hold_clear),
    .din   (capture_entry),
    .dout  (hold_entry),
    .full  (hold_full)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_reg;
    req        = 1'b0;
    addr       = pc_reg;
    load       = 1'b0;
    load_entry = '0;
    hold_load  = 1'b0;
    hold_clear = 1'b0;
    unique case (state_q)
      IF_IDLE: begin
        req = !redirect_valid;
        if (req && imem.ready) state_d = IF_WAIT;
      end
      IF_WAIT: begin
        if (imem.rvalid) begin
          if (redirect_valid) begin
            state_d = IF_IDLE;
          end else if (stall) begin
            hold_load = 1'b1;
            state_d   = IF_HOLD;
          end else begin
            // Deliver and immediately chain the next sequential fetch.
            load       = 1'b1;
            load_entry = capture_entry;
            pc_d       = pc_plus4;
            req        = 1'b1;
            addr       = pc_plus4;
            state_d    = imem.ready ? IF_WAIT : IF_IDLE;
          end
        end else if (redirect_valid) begin
          state_d = IF_DISCARD;
        end
      end
      IF_HOLD: begin
        if (redirect_valid) begin
          hold_clear = 1'b1;
          state_d    = IF_IDLE;
        end else if (!stall && hold_full) begin
          load       = 1'b1;
          load_entry = hold_entry;
          pc_d       = pc_plus4;
          hold_clear = 1'b1;
          state_d    = IF_IDLE;
        end
      end
      IF_DISCARD: begin
        if (imem.rvalid) state_d = IF_IDLE;
      end
      default: state_d = IF_IDLE;
    endcase
    if (redirect_valid) pc_d = align_pc(redirect_pc);
  end

  assign imem.req  = req && !reset;
  assign imem.addr = addr;
  assign fsm_state = state_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= IF_IDLE;
      pc_reg            <= RESET_PC;
      fetch_count       <= '0;
      if_id_valid       <= 1'b0;
      if_id_instruction <= NOP_INSTR;
      if_id_pc          <= '0;
    end else begin
      state_q <= state_d;
      pc_reg  <= pc_d;
      // IF/ID priority: redirect/flush bubble, then stall hold, then load, else bubble.
      if (redirect_valid || flush) begin
        if_id_valid       <= 1'b0;
        if_id_instruction <= NOP_INSTR;
      end else if (!stall) begin
        if (load) begin
          if_id_valid       <= 1'b1;
          if_id_instruction <= load_entry.instr;
          if_id_pc          <= load_entry.pc;
          fetch_count       <= fetch_count + 32'd1;
        end else begin
          if_id_valid       <= 1'b0;
          if_id_instruction <= NOP_INSTR;
        end
      end
    end
  end

endmodule
